// File: rtl/gray_seq_detector_if.sv
// Bus between the Gray sequence detector and its driver: counter controls,
// watched transition pattern, and the registered count/detection outputs.
interface gray_seq_detector_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             enable;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] pat_from;
    logic [WIDTH-1:0] pat_to;
    logic             det_clr;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             detector;
    logic             wrap;
    logic [CNT_W-1:0] det_count;

    modport master (
        output enable, up_dn, load, load_val, pat_from, pat_to, det_clr,
        input  bin_out, gray_out, detector, wrap, det_count
    );

    modport slave (
        input  enable, up_dn, load, load_val, pat_from, pat_to, det_clr,
        output bin_out, gray_out, detector, wrap, det_count
    );
endinterface

// File: rtl/gray_seq_detector.sv
// Up/down binary counter with a registered Gray view that pulses detector when
// a step moves the Gray code from pat_from to pat_to, and counts detections.
module gray_seq_detector #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    gray_seq_detector_if.slave    bus
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             det_q;
    logic             wrap_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             det_d;
    logic             wrap_d;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] step_bin;
    logic [WIDTH-1:0] step_gray;
    logic             step;

    // Gray is registered from the next binary value so both outputs change together.
    always_comb begin
        bin_d     = bin_q;
        gray_d    = gray_q;
        det_d     = 1'b0;
        wrap_d    = 1'b0;
        cnt_d     = cnt_q;
        step      = bus.enable && !bus.load;
        step_bin  = bus.up_dn ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
        step_gray = step_bin ^ (step_bin >> 1);

        if (bus.load) begin
            bin_d  = bus.load_val;
            gray_d = bus.load_val ^ (bus.load_val >> 1);
        end else if (step) begin
            bin_d  = step_bin;
            gray_d = step_gray;
            det_d  = (gray_q == bus.pat_from) && (step_gray == bus.pat_to);
            wrap_d = bus.up_dn ? (&bin_q) : (bin_q == '0);
        end

        // A clear coinciding with a detection leaves that detection counted.
        if (bus.det_clr) begin
            cnt_d = det_d ? CNT_W'(1) : '0;
        end else if (det_d && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            det_q  <= 1'b0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            det_q  <= det_d;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.bin_out   = bin_q;
    assign bus.gray_out  = gray_q;
    assign bus.detector  = det_q;
    assign bus.wrap      = wrap_q;
    assign bus.det_count = cnt_q;

endmodule

// File: tb/tb_gray_seq_detector.sv
// Self-checking bench for gray_seq_detector (WIDTH=4, CNT_W=2): directed vector
// table, hand-written saturation/reset sequences, and random traffic vs a model.
module tb_gray_seq_detector;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int   m_bin;
    logic m_det;
    logic m_wrap;
    int   m_cnt;

    gray_seq_detector_if #(.WIDTH(4), .CNT_W(2)) bus ();

    gray_seq_detector #(.WIDTH(4), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic [3:0] load_val;
        logic       enable;
        logic       up_dn;
        logic [3:0] pat_from;
        logic [3:0] pat_to;
        logic       det_clr;
        logic [3:0] e_bin;
        logic [3:0] e_gray;
        logic       e_det;
        logic       e_wrap;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vec [17];

    function automatic int gray(int x);
        return (x ^ (x >> 1)) & 15;
    endfunction

    // Drive one cycle of inputs, advance the reference model, clock, settle.
    task automatic applyStimulus(input logic ld, input logic [3:0] ld_val,
                                 input logic en, input logic up,
                                 input logic [3:0] pf, input logic [3:0] pt,
                                 input logic clr);
        int nb;
        bus.load     = ld;
        bus.load_val = ld_val;
        bus.enable   = en;
        bus.up_dn    = up;
        bus.pat_from = pf;
        bus.pat_to   = pt;
        bus.det_clr  = clr;
        m_det  = 1'b0;
        m_wrap = 1'b0;
        if (ld) begin
            m_bin = int'(ld_val);
        end else if (en) begin
            nb     = (m_bin + (up ? 1 : 15)) % 16;
            m_det  = (gray(m_bin) == int'(pf)) && (gray(nb) == int'(pt));
            m_wrap = up ? (nb < m_bin) : (nb > m_bin);
            m_bin  = nb;
        end
        if (clr) m_cnt = m_det ? 1 : 0;
        else if (m_det && m_cnt < 3) m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_bin,
                               input logic [3:0] e_gray, input logic e_det,
                               input logic e_wrap, input logic [1:0] e_cnt);
        checks++;
        if (bus.bin_out !== e_bin) begin
            errors++;
            $display("[TB] FAIL %s bin_out got %0d expected %0d", name, bus.bin_out, e_bin);
        end
        checks++;
        if (bus.gray_out !== e_gray) begin
            errors++;
            $display("[TB] FAIL %s gray_out got %b expected %b", name, bus.gray_out, e_gray);
        end
        checks++;
        if (bus.detector !== e_det) begin
            errors++;
            $display("[TB] FAIL %s detector got %b expected %b", name, bus.detector, e_det);
        end
        checks++;
        if (bus.wrap !== e_wrap) begin
            errors++;
            $display("[TB] FAIL %s wrap got %b expected %b", name, bus.wrap, e_wrap);
        end
        checks++;
        if (bus.det_count !== e_cnt) begin
            errors++;
            $display("[TB] FAIL %s det_count got %0d expected %0d", name, bus.det_count, e_cnt);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, 4'(m_bin), 4'(gray(m_bin)), m_det, m_wrap, 2'(m_cnt));
    endtask

    task automatic resetModel();
        m_bin  = 0;
        m_det  = 1'b0;
        m_wrap = 1'b0;
        m_cnt  = 0;
    endtask

    initial begin
        logic [1:0] sat_exp [4];
        logic       ld, en, up, clr;
        logic [3:0] lv, pf, pt;

        checks = 0;
        errors = 0;
        bus.load = 1'b0; bus.load_val = '0; bus.enable = 1'b0; bus.up_dn = 1'b1;
        bus.pat_from = '0; bus.pat_to = '0; bus.det_clr = 1'b0;

        // Counting up through 0100 -> 1100, then load/step-down/wrap/hold cases.
        vec[0]  = '{0, 0, 1, 1, 4, 12, 0, 1,  1, 0, 0, 0};
        vec[1]  = '{0, 0, 1, 1, 4, 12, 0, 2,  3, 0, 0, 0};
        vec[2]  = '{0, 0, 1, 1, 4, 12, 0, 3,  2, 0, 0, 0};
        vec[3]  = '{0, 0, 1, 1, 4, 12, 0, 4,  6, 0, 0, 0};
        vec[4]  = '{0, 0, 1, 1, 4, 12, 0, 5,  7, 0, 0, 0};
        vec[5]  = '{0, 0, 1, 1, 4, 12, 0, 6,  5, 0, 0, 0};
        vec[6]  = '{0, 0, 1, 1, 4, 12, 0, 7,  4, 0, 0, 0};
        vec[7]  = '{0, 0, 1, 1, 4, 12, 0, 8, 12, 1, 0, 1};
        vec[8]  = '{1, 8, 1, 0, 12, 4, 0, 8, 12, 0, 0, 1};
        vec[9]  = '{0, 0, 1, 0, 12, 4, 0, 7,  4, 1, 0, 2};
        vec[10] = '{0, 0, 0, 0, 12, 4, 0, 7,  4, 0, 0, 2};
        vec[11] = '{1, 15, 0, 1, 0, 0, 0, 15, 8, 0, 0, 2};
        vec[12] = '{0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 1, 2};
        vec[13] = '{0, 0, 1, 0, 0, 0, 0, 15, 8, 0, 1, 2};
        vec[14] = '{0, 0, 0, 0, 0, 0, 0, 15, 8, 0, 0, 2};
        vec[15] = '{1, 8, 0, 1, 4, 12, 0, 8, 12, 0, 0, 2};
        vec[16] = '{0, 0, 0, 1, 4, 12, 1, 8, 12, 0, 0, 0};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3};

        rst = 1'b1;
        resetModel();
        #1;
        checkOutput("reset", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vec[i].load, vec[i].load_val, vec[i].enable, vec[i].up_dn,
                          vec[i].pat_from, vec[i].pat_to, vec[i].det_clr);
            checkOutput($sformatf("vec%0d", i), vec[i].e_bin, vec[i].e_gray,
                        vec[i].e_det, vec[i].e_wrap, vec[i].e_cnt);
        end

        // Repeated 7 -> 8 steps drive the 2-bit detection count into saturation.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 4'd7, 1'b0, 1'b1, 4'd4, 4'd12, 1'b0);
            applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 4'd12, 1'b0);
            checkOutput($sformatf("sat%0d", k), 4'd8, 4'd12, 1'b1, 1'b0, sat_exp[k]);
        end
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b1, 4'd4, 4'd12, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 4'd12, 1'b1);
        checkOutput("clr_with_det", 4'd8, 4'd12, 1'b1, 1'b0, 2'd1);

        // Asynchronous reset while the 7 -> 8 detecting step is pending.
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b1, 4'd4, 4'd12, 1'b0);
        bus.enable = 1'b1;
        bus.load   = 1'b0;
        #2;
        rst = 1'b1;
        resetModel();
        #1;
        checkOutput("async_rst", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_held", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 4'd12, 1'b0);
        checkOutput("after_rst", 4'd1, 4'd1, 1'b0, 1'b0, 2'd0);

        // Random traffic, biased so patterns often match the live transition.
        for (int n = 0; n < 400; n++) begin
            ld  = ($urandom_range(0, 99) < 8);
            lv  = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 3) != 0);
            up  = 1'($urandom_range(0, 1));
            pf  = $urandom_range(0, 1) ? 4'(gray(m_bin)) : 4'($urandom_range(0, 15));
            pt  = $urandom_range(0, 2) != 0 ? 4'(gray((m_bin + (up ? 1 : 15)) % 16))
                                            : 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 19) == 0);
            applyStimulus(ld, lv, en, up, pf, pt, clr);
            checkModel($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
